// File: rtl/sma_cs_inv.sv
// Inverse 4-tap moving-sum: rebuilds signed samples from the running window sum, 2-entry output FIFO.
// Optional overflow flag err_ovf is built only when SMA_CS_INV_CHECK_EN is defined.
module sma_cs_inv #(
   parameter int DATA_W = 16,
   parameter int TAPS   = 4,
   parameter int SUM_W  = DATA_W + $clog2(TAPS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [SUM_W-1:0]  in_sum,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_x
`ifdef SMA_CS_INV_CHECK_EN
   ,output logic                    err_ovf
`endif
);

   localparam int D_W = SUM_W + 2;

   logic [1:0]               count;
   logic signed [DATA_W-1:0] fifo_p1 [2];
   logic signed [SUM_W-1:0]  s_prev;
   logic signed [DATA_W-1:0] x_hist [TAPS];
   logic signed [D_W-1:0]    d_p0;
   logic signed [DATA_W-1:0] x_p0;
   logic                     push;
   logic                     pop;

   function automatic logic signed [DATA_W-1:0] wrap_data(input logic signed [D_W-1:0] d);
      return DATA_W'(d);
   endfunction

`ifdef SMA_CS_INV_CHECK_EN
   localparam logic signed [D_W-1:0] X_MAX = D_W'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
   localparam logic signed [D_W-1:0] X_MIN = -D_W'(64'sd1 <<< (DATA_W-1));

   function automatic logic out_of_range(input logic signed [D_W-1:0] d);
      return (d > X_MAX) || (d < X_MIN);
   endfunction
`endif

   assign in_ready  = (count < 2'd2);
   assign out_valid = (count != 2'd0);
   assign out_x     = fifo_p1[0];
   assign push      = in_valid & in_ready & ~clear;
   assign pop       = out_valid & out_ready & ~clear;

   // Stage p0: difference of consecutive sums plus the sample leaving the window
   assign d_p0 = D_W'(in_sum) - D_W'(s_prev) + D_W'(x_hist[TAPS-1]);
   assign x_p0 = wrap_data(d_p0);

   // Stage p1: history update and FIFO (head always in slot 0)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count      <= 2'd0;
         s_prev     <= '0;
         fifo_p1[0] <= '0;
         fifo_p1[1] <= '0;
         for (int i = 0; i < TAPS; i++) x_hist[i] <= '0;
      end else if (clear) begin
         count      <= 2'd0;
         s_prev     <= '0;
         fifo_p1[0] <= '0;
         fifo_p1[1] <= '0;
         for (int i = 0; i < TAPS; i++) x_hist[i] <= '0;
      end else begin
         if (push) begin
            s_prev    <= in_sum;
            x_hist[0] <= x_p0;
            for (int i = 1; i < TAPS; i++) x_hist[i] <= x_hist[i-1];
         end
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) fifo_p1[0] <= x_p0;
               else               fifo_p1[1] <= x_p0;
               count <= count + 2'd1;
            end
            2'b01: begin
               fifo_p1[0] <= fifo_p1[1];
               count      <= count - 2'd1;
            end
            // push can only coincide with pop at count==1, so the new sample becomes head
            2'b11:   fifo_p1[0] <= x_p0;
            default: begin end
         endcase
      end
   end

`ifdef SMA_CS_INV_CHECK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                            err_ovf <= 1'b0;
      else if (push && out_of_range(d_p0)) err_ovf <= 1'b1;
   end
`endif

endmodule
